// File: rtl/tt_microtile_pwm_bank.sv
// Multi-channel PWM bank for a microtile slot: strobe-driven duty writes into shadow
// registers, promoted to the active set only at a period boundary so outputs never glitch.
//
// Write FSM (WIDTH=8 only)
// state | meaning
// IDLE  | waiting for the low-nibble write (latches channel and low nibble)
// HALF  | low nibble held, next strobe edge supplies the high nibble and commits
`timescale 1ns/1ps
module tt_microtile_pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  localparam logic [7:0]       PRE_MAX = 8'((1 << PRESCALE) - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [7:0]          s1;
  logic [7:0]          s2;
  logic                prev;
  logic                strobe_edge;
  logic [7:0]          pre;
  logic                tick;
  logic                wrap;
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [WIDTH-1:0]    active [CHANNELS];
  logic [CHANNELS-1:0] pwm;
  logic                commit;
  logic [2:0]          commit_chan;
  logic [WIDTH-1:0]    commit_data;

  // prev resets high so a strobe already high when reset releases is not seen as an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= 1'b1;
    end else begin
      s1   <= ui_in;
      s2   <= s1;
      prev <= s2[7];
    end
  end

  assign strobe_edge = s2[7] & ~prev;

  generate
    if (WIDTH == 8) begin : g_two_phase
      typedef enum logic {IDLE, HALF} state_t;
      state_t     state;
      logic [2:0] chan;
      logic [3:0] lo;

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= IDLE;
          chan  <= '0;
          lo    <= '0;
        end else if (strobe_edge) begin
          case (state)
            IDLE: begin
              chan  <= s2[6:4];
              lo    <= s2[3:0];
              state <= HALF;
            end
            HALF: state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end

      assign commit      = strobe_edge & (state == HALF);
      assign commit_chan = chan;
      assign commit_data = {s2[3:0], lo};
    end else begin : g_single
      assign commit      = strobe_edge;
      assign commit_chan = s2[6:4];
      assign commit_data = s2[3:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 8'd1;
    end
  end

  assign tick = (pre == PRE_MAX);
  assign wrap = tick & (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  // Out-of-range channels simply match no slot, so their commits fall away.
  // The wrap load reads shadow before a same-cycle commit lands, deferring it a period.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pwm <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wrap) active[i] <= shadow[i];
        if (commit && (commit_chan == 3'(i))) shadow[i] <= commit_data;
        pwm[i] <= (cnt < active[i]);
      end
    end
  end

  always_comb begin
    uo_out = '0;
    uo_out[CHANNELS-1:0] = pwm;
  end

endmodule

// File: tb/tb_tt_microtile_pwm_bank.sv
// Scoreboard bench: a period-arithmetic reference model queues the expected pins for two
// bank configurations every clock; an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_tt_microtile_pwm_bank;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui8, ui4, uo8, uo4;

  always #5 clk = ~clk;

  tt_microtile_pwm_bank #(.CHANNELS(4), .WIDTH(8), .PRESCALE(0)) dut8 (
    .clk(clk), .rst(rst), .ui_in(ui8), .uo_out(uo8));
  tt_microtile_pwm_bank #(.CHANNELS(4), .WIDTH(4), .PRESCALE(1)) dut4 (
    .clk(clk), .rst(rst), .ui_in(ui4), .uo_out(uo4));

  typedef struct {
    string name;
    int    act;
    int    exp;
  } dchk_t;

  logic [15:0] exp_q[$];
  dchk_t       dir_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          done = 1'b0;

  // model state, index 0 = WIDTH 8 / PRESCALE 0 bank, index 1 = WIDTH 4 / PRESCALE 1 bank
  int         mw[2] = '{8, 4};
  int         mp[2] = '{0, 1};
  int         shadow_m[2][8];
  int         active_m[2][8];
  int         t_m[2];
  int         mch[2];
  int         mlo[2];
  bit         half_m[2];
  bit         sprev[2];
  logic [7:0] ua[2];
  logic [7:0] ub[2];
  int         hc8[8];
  int         hc4[8];

  function automatic int period(input int m);
    return 1 << (mw[m] + mp[m]);
  endfunction

  // One clock of the reference: t counts clocks since reset, so the count position and
  // the period boundary follow directly from the period arithmetic.
  task automatic model_edge(input int m, input logic r, input logic [7:0] ui,
                            output logic [7:0] e);
    int         per;
    int         pos;
    logic [7:0] seen;
    e = '0;
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        shadow_m[m][i] = 0;
        active_m[m][i] = 0;
      end
      t_m[m] = 0; half_m[m] = 1'b0; mch[m] = 0; mlo[m] = 0;
      ua[m] = '0; ub[m] = '0; sprev[m] = 1'b1;
    end else begin
      per = period(m);
      t_m[m]++;
      pos = ((t_m[m] - 1) % per) >> mp[m];
      for (int i = 0; i < NCH; i++) e[i] = (pos < active_m[m][i]);
      if (t_m[m] % per == 0)
        for (int i = 0; i < 8; i++) active_m[m][i] = shadow_m[m][i];
      seen = ub[m];
      if (seen[7] && !sprev[m]) begin
        if (mw[m] == 4) begin
          if (int'(seen[6:4]) < NCH) shadow_m[m][int'(seen[6:4])] = int'(seen[3:0]);
        end else if (!half_m[m]) begin
          half_m[m] = 1'b1;
          mch[m] = int'(seen[6:4]);
          mlo[m] = int'(seen[3:0]);
        end else begin
          half_m[m] = 1'b0;
          if (mch[m] < NCH) shadow_m[m][mch[m]] = int'(seen[3:0]) * 16 + mlo[m];
        end
      end
      sprev[m] = seen[7];
      ub[m] = ua[m];
      ua[m] = ui;
    end
  endtask

  task automatic step();
    logic [7:0] e8, e4;
    @(posedge clk);
    #1;
    model_edge(0, rst, ui8, e8);
    model_edge(1, rst, ui4, e4);
    exp_q.push_back({e4, e8});
    for (int i = 0; i < 8; i++) begin
      hc8[i] += int'(uo8[i]);
      hc4[i] += int'(uo4[i]);
    end
  endtask

  task automatic dcheck(input string n, input int a, input int e);
    dchk_t d;
    d.name = n; d.act = a; d.exp = e;
    dir_q.push_back(d);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) begin
      hc8[i] = 0;
      hc4[i] = 0;
    end
  endtask

  task automatic measure(input int n);
    clear_counts();
    repeat (n) step();
  endtask

  task automatic run_to_wrap(input int m);
    int n = 0;
    do begin
      step();
      n++;
    end while ((t_m[m] % period(m)) != 0 && n < 3000);
    if (n >= 3000) dcheck("wrap_timeout", 0, 1);
  endtask

  task automatic wr_edge(input bit to4, input logic [2:0] ch, input logic [3:0] d);
    int hw = $urandom_range(4, 2);
    int lw = $urandom_range(4, 2);
    if (to4) ui4 = {1'b1, ch, d}; else ui8 = {1'b1, ch, d};
    repeat (hw) step();
    if (to4) ui4 = {1'b0, ch, d}; else ui8 = {1'b0, ch, d};
    repeat (lw) step();
  endtask

  task automatic wr_pair(input logic [2:0] ch, input logic [7:0] duty);
    wr_edge(1'b0, ch, duty[3:0]);
    wr_edge(1'b0, 3'($urandom_range(7, 0)), duty[7:4]);
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    dchk_t       d;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({uo4, uo8} !== e) begin
        failures++;
        if (failures <= 20)
          $display("FAIL pwm_pins t=%0t got uo4=%h uo8=%h want uo4=%h uo8=%h",
                   $time, uo4, uo8, e[15:8], e[7:0]);
      end
    end
    while (dir_q.size() > 0) begin
      d = dir_q.pop_front();
      checks++;
      if (d.act != d.exp) begin
        failures++;
        $display("FAIL %s got %0d want %0d", d.name, d.act, d.exp);
      end
    end
    if (done && exp_q.size() == 0 && dir_q.size() == 0) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    int n;
    rst = 1'b1; ui8 = 8'hFF; ui4 = 8'hFF;
    repeat (3) step();
    rst = 1'b0;
    measure(512);
    dcheck("reset_hold_bank8_high", hc8[0] + hc8[1] + hc8[2] + hc8[3] + hc8[4] + hc8[5] + hc8[6] + hc8[7], 0);
    dcheck("reset_hold_bank4_high", hc4[0] + hc4[1] + hc4[2] + hc4[3] + hc4[4] + hc4[5] + hc4[6] + hc4[7], 0);

    rst = 1'b1; ui8 = 8'h00; ui4 = 8'h00;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();

    wr_edge(1'b0, 3'd1, 4'h0);
    wr_edge(1'b0, 3'd6, 4'h4);
    run_to_wrap(0);
    measure(256);
    dcheck("two_phase_ch1_high", hc8[1], 64);
    dcheck("two_phase_other_high", hc8[0] + hc8[2] + hc8[3] + hc8[4] + hc8[5] + hc8[6] + hc8[7], 0);

    wr_pair(3'd0, 8'h00);
    wr_pair(3'd3, 8'hFF);
    run_to_wrap(0);
    measure(256);
    dcheck("duty_zero_ch0_high", hc8[0], 0);
    dcheck("duty_max_ch3_high", hc8[3], 255);
    dcheck("upper_pins_high", hc8[4] + hc8[5] + hc8[6] + hc8[7], 0);

    wr_pair(3'd5, 8'($urandom));
    wr_pair(3'd2, 8'h80);
    run_to_wrap(0);
    measure(256);
    dcheck("after_oor_ch2_high", hc8[2], 128);
    dcheck("after_oor_ch1_high", hc8[1], 64);
    dcheck("after_oor_ch3_high", hc8[3], 255);

    wr_edge(1'b0, 3'd0, 4'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_edge(1'b0, 3'd0, 4'h0);
    n = 0;
    while (((t_m[0] + 3) % 256) != 0 && n < 600) begin
      step();
      n++;
    end
    if (n >= 600) dcheck("align_timeout", 0, 1);
    clear_counts();
    wr_edge(1'b0, 3'd3, 4'h1);
    run_to_wrap(0);
    dcheck("collision_period_ch0_high", hc8[0], 0);
    measure(256);
    dcheck("collision_later_ch0_high", hc8[0], 16);

    wr_edge(1'b1, 3'd2, 4'hA);
    run_to_wrap(1);
    measure(32);
    dcheck("w4_ch2_high", hc4[2], 20);
    dcheck("w4_other_high", hc4[0] + hc4[1] + hc4[3] + hc4[4] + hc4[5] + hc4[6] + hc4[7], 0);

    for (int it = 0; it < 40; it++) begin
      int a = $urandom_range(9, 0);
      if (a < 3) wr_pair(3'($urandom_range(7, 0)), 8'($urandom));
      else if (a < 4) wr_edge(1'b0, 3'($urandom_range(7, 0)), 4'($urandom));
      else if (a < 6) wr_edge(1'b1, 3'($urandom_range(7, 0)), 4'($urandom));
      else if (a == 6) begin
        rst = 1'b1;
        repeat ($urandom_range(2, 1)) step();
        rst = 1'b0;
      end else begin
        repeat ($urandom_range(300, 1)) step();
      end
    end
    repeat (300) step();
    done = 1'b1;
    repeat (20) @(posedge clk);
    $display("FAIL scoreboard_drain pending=%0d want 0", exp_q.size() + dir_q.size());
    $fatal(1);
  end

endmodule
